// File: rtl/pc_pkg.sv
// Shared defaults and the fetch-state type for the program-counter fetch unit.
package pc_pkg;

    localparam int          ADDR_W_DEF   = 32;
    localparam int          INC_DEF      = 4;
    localparam int          INSTR_W      = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic {
        WAIT = 1'b0,
        REQ  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_slot.sv
// Single-entry output register between fetch and decode: load, flush, handshake clear.
module fetch_slot
    import pc_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = INSTR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              flush,
    input  logic              ready,
    input  logic [DATA_W-1:0] load_data,
    input  logic [ADDR_W-1:0] load_pc,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [ADDR_W-1:0] pc
);

    // Flush beats a refill; a refill beats the handshake clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            pc    <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            pc    <= load_pc;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter, instruction-memory fetch FSM and decode hand-off slot.
// Optional redirect alignment check is enabled by defining PC_ALIGN_CHECK_EN.
module pc_fetch_unit
    import pc_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
    parameter int                INC      = INC_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               instr_ready,
    output logic               misalign_err
);

    fetch_state_e      state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_tgt;
    logic [ADDR_W-1:0] pc_inc;
    logic              discard;
    logic              redir;
    logic              go;
    logic              slot_load;

`ifdef PC_ALIGN_CHECK_EN
    logic misaligned;

    assign misaligned = (redirect_pc % ADDR_W'(INC)) != '0;
    assign redir      = redirect_valid && !misaligned;

    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_err <= 1'b0;
        end else if (redirect_valid && misaligned) begin
            misalign_err <= 1'b1;
        end
    end
`else
    assign redir        = redirect_valid;
    assign misalign_err = 1'b0;
`endif

    // imem: req is held with a stable addr until ack. decode: a transfer
    // happens on every cycle where instr_valid && instr_ready are both high.
    assign imem_req  = (state == REQ);
    assign imem_addr = pc;
    assign pc_inc    = pc + ADDR_W'(INC);
    assign go        = !stall && (!instr_valid || instr_ready);
    assign slot_load = (state == REQ) && imem_ack && !discard && !redir;

    // pc only moves when no request is outstanding, which keeps imem_addr
    // stable; a redirect during a request parks in pc_tgt until the ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= WAIT;
            pc      <= RESET_PC;
            pc_tgt  <= RESET_PC;
            discard <= 1'b0;
        end else begin
            case (state)
                WAIT: begin
                    if (redir) begin
                        pc <= redirect_pc;
                    end
                    if (go) begin
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (imem_ack) begin
                        state   <= WAIT;
                        discard <= 1'b0;
                        if (redir) begin
                            pc <= redirect_pc;
                        end else if (discard) begin
                            pc <= pc_tgt;
                        end else begin
                            pc <= pc_inc;
                        end
                    end else if (redir) begin
                        pc_tgt  <= redirect_pc;
                        discard <= 1'b1;
                    end
                end
                default: state <= WAIT;
            endcase
        end
    end

    fetch_slot #(
        .ADDR_W (ADDR_W),
        .DATA_W (INSTR_W)
    ) u_slot (
        .clk       (clk),
        .rst       (rst),
        .load      (slot_load),
        .flush     (redir),
        .ready     (instr_ready),
        .load_data (imem_rdata),
        .load_pc   (pc),
        .valid     (instr_valid),
        .data      (instr),
        .pc        (instr_pc)
    );

endmodule
